// File: rtl/mod_segment_swap_ctrl.sv
// mod_segment_swap_ctrl
// Chooses which modulation segment the sampler reads. A settings UPDATE arms
// a segment change. The change is applied when the selected transition
// condition is met. The block also counts completed loops of the active segment
// and raises STOP once a finite repeat count has been used up.
module mod_segment_swap_ctrl #(
    parameter int IDX_W  = 15,
    parameter int REP_W  = 16,
    parameter int GPIO_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              UPDATE,
    input  logic              REQ_RD_SEGMENT,
    input  logic [7:0]        TRANSITION_MODE,
    input  logic [63:0]       TRANSITION_VALUE,
    input  logic [REP_W-1:0]  REP,
    input  logic [63:0]       SYS_TIME,
    input  logic [GPIO_W-1:0] GPIO_IN,
    input  logic              IDX_STEP,
    input  logic [IDX_W-1:0]  IDX,
    input  logic [IDX_W-1:0]  CYCLE,
    output logic              SEGMENT,
    output logic              STOP,
    output logic              BUSY,
    output logic [REP_W-1:0]  LOOP_CNT,
    output logic              ERR_MODE
);

    localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
    localparam logic [7:0] MODE_SYS_TIME = 8'h01;
    localparam logic [7:0] MODE_GPIO     = 8'h02;
    localparam logic [7:0] MODE_IMM      = 8'hFF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Architectural state
    state_t             state_q, state_d;
    logic               seg_q, seg_d;          // active segment
    logic               stop_q, stop_d;
    logic               busy_q, busy_d;
    logic [REP_W-1:0]   loop_cnt_q, loop_cnt_d;
    logic               err_q, err_d;
    logic [REP_W-1:0]   act_rep_q, act_rep_d;  // repeat setting of the active segment

    // Pending request, captured on a valid UPDATE
    logic               req_seg_q, req_seg_d;
    logic [7:0]         mode_q, mode_d;
    logic [63:0]        value_q, value_d;
    logic [REP_W-1:0]   req_rep_q, req_rep_d;

    // Previous-cycle GPIO sample, kept every cycle regardless of state
    logic [GPIO_W-1:0]  gpio_prev_q;

    logic               wrap;
    logic               mode_valid;
    logic               cond;
    logic [GPIO_W-1:0]  gpio_rise;
    logic [GPIO_W-1:0]  gpio_match;
    logic               gpio_hit;

    // The segment length is tracked by the sampler itself. A wrap is seen here
    // only as a step back to index 0, so CYCLE has no role in this block.
    logic               unused_cycle;
    assign unused_cycle = ^CYCLE;

    assign wrap       = IDX_STEP && (IDX == '0);
    assign mode_valid = (TRANSITION_MODE == MODE_SYNC_IDX) ||
                        (TRANSITION_MODE == MODE_SYS_TIME) ||
                        (TRANSITION_MODE == MODE_GPIO)     ||
                        (TRANSITION_MODE == MODE_IMM);

    assign gpio_rise = GPIO_IN & ~gpio_prev_q;

    // Only GPIO numbers 0..3 can be addressed through value[1:0]. Any wider
    // GPIO bits therefore never match.
    generate
        for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_gpio_sel
            if (gi < 4) begin : g_addr
                assign gpio_match[gi] = gpio_rise[gi] && (value_q[1:0] == 2'(gi));
            end else begin : g_noaddr
                assign gpio_match[gi] = 1'b0;
            end
        end
    endgenerate

    assign gpio_hit = |gpio_match;

    // Evaluate the armed transition condition, valid only while waiting
    always_comb begin
        cond = 1'b0;
        if (state_q == ST_WAIT) begin
            case (mode_q)
                MODE_SYNC_IDX: cond = wrap;
                MODE_SYS_TIME: cond = (SYS_TIME >= value_q);
                MODE_GPIO:     cond = gpio_hit;
                MODE_IMM:      cond = 1'b1;
                default:       cond = 1'b0;
            endcase
        end
    end

    // Next-state logic. Loop counting is applied first, then a switch or a new
    // request overrides it, which gives the required priorities.
    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        stop_d     = stop_q;
        busy_d     = busy_q;
        loop_cnt_d = loop_cnt_q;
        err_d      = err_q;
        act_rep_d  = act_rep_q;
        req_seg_d  = req_seg_q;
        mode_d     = mode_q;
        value_d    = value_q;
        req_rep_d  = req_rep_q;

        // The active segment keeps counting in both states. The count freezes
        // once STOP is set.
        if (wrap && !stop_q) begin
            if (loop_cnt_q != '1) begin
                loop_cnt_d = loop_cnt_q + 1'b1;
            end
            // A count equal to REP before this wrap means REP+1 loops are now done.
            if ((act_rep_q != '1) && (loop_cnt_q == act_rep_q)) begin
                stop_d = 1'b1;
            end
        end

        if (UPDATE && mode_valid) begin
            // A new request replaces any pending one, including one whose
            // condition fires in this same cycle.
            req_seg_d = REQ_RD_SEGMENT;
            mode_d    = TRANSITION_MODE;
            value_d   = TRANSITION_VALUE;
            req_rep_d = REP;
            state_d   = ST_WAIT;
            busy_d    = 1'b1;
        end else begin
            if (UPDATE) begin
                err_d = 1'b1;
            end
            if (cond) begin
                // A switch takes priority over a coincident wrap, so that wrap is not counted.
                seg_d      = req_seg_q;
                act_rep_d  = req_rep_q;
                loop_cnt_d = '0;
                stop_d     = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_RUN;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            seg_q       <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
            loop_cnt_q  <= '0;
            err_q       <= 1'b0;
            act_rep_q   <= '1;
            req_seg_q   <= 1'b0;
            mode_q      <= MODE_IMM;
            value_q     <= '0;
            req_rep_q   <= '1;
            gpio_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            stop_q      <= stop_d;
            busy_q      <= busy_d;
            loop_cnt_q  <= loop_cnt_d;
            err_q       <= err_d;
            act_rep_q   <= act_rep_d;
            req_seg_q   <= req_seg_d;
            mode_q      <= mode_d;
            value_q     <= value_d;
            req_rep_q   <= req_rep_d;
            gpio_prev_q <= GPIO_IN;
        end
    end

    assign SEGMENT  = seg_q;
    assign STOP     = stop_q;
    assign BUSY     = busy_q;
    assign LOOP_CNT = loop_cnt_q;
    assign ERR_MODE = err_q;

endmodule

// File: tb/tb_mod_segment_swap_ctrl.sv
// Bench for mod_segment_swap_ctrl: directed stimulus pushes the expected
// outputs into a queue. A negedge monitor pops each entry and compares it.
module tb_mod_segment_swap_ctrl;

    logic        CLK;
    logic        RST;
    logic        UPDATE;
    logic        REQ_RD_SEGMENT;
    logic [7:0]  TRANSITION_MODE;
    logic [63:0] TRANSITION_VALUE;
    logic [15:0] REP;
    logic [63:0] SYS_TIME;
    logic [3:0]  GPIO_IN;
    logic        IDX_STEP;
    logic [14:0] IDX;
    logic [14:0] CYCLE;
    logic        SEGMENT;
    logic        STOP;
    logic        BUSY;
    logic [15:0] LOOP_CNT;
    logic        ERR_MODE;

    mod_segment_swap_ctrl #(.IDX_W(15), .REP_W(16), .GPIO_W(4)) dut (
        .CLK(CLK), .RST(RST), .UPDATE(UPDATE), .REQ_RD_SEGMENT(REQ_RD_SEGMENT),
        .TRANSITION_MODE(TRANSITION_MODE), .TRANSITION_VALUE(TRANSITION_VALUE),
        .REP(REP), .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN), .IDX_STEP(IDX_STEP),
        .IDX(IDX), .CYCLE(CYCLE), .SEGMENT(SEGMENT), .STOP(STOP), .BUSY(BUSY),
        .LOOP_CNT(LOOP_CNT), .ERR_MODE(ERR_MODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: due cycle, expected {seg,stop,busy,loop,err}, name
    int          due_q[$];
    logic [19:0] val_q[$];
    string       name_q[$];

    int   checks = 0;
    int   errors = 0;
    logic stim_done = 1'b0;
    logic final_done = 1'b0;

    always @(negedge CLK) begin
        logic [19:0] act;
        logic [19:0] exp_v;
        int          due;
        string       nm;
        act = {SEGMENT, STOP, BUSY, LOOP_CNT, ERR_MODE};
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            due   = due_q.pop_front();
            exp_v = val_q.pop_front();
            nm    = name_q.pop_front();
            checks++;
            if (due != cyc || act !== exp_v) begin
                errors++;
                $display("FAIL %s cyc=%0d seg/stop/busy/loop/err got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                         nm, cyc, act[19], act[18], act[17], act[16:1], act[0],
                         exp_v[19], exp_v[18], exp_v[17], exp_v[16:1], exp_v[0]);
            end else begin
                $display("ok   %s cyc=%0d seg/stop/busy/loop/err %0d/%0d/%0d/%0d/%0d",
                         nm, cyc, act[19], act[18], act[17], act[16:1], act[0]);
            end
        end
        if (stim_done && !final_done) begin
            checks++;
            if (due_q.size() != 0) begin
                errors++;
                $display("FAIL drain unchecked entries got %0d expected 0", due_q.size());
            end
            final_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic s, input logic st,
                              input logic b, input logic [15:0] l, input logic e);
        due_q.push_back(cyc);
        val_q.push_back({s, st, b, l, e});
        name_q.push_back(nm);
    endtask

    task automatic arm(input logic seg, input logic [7:0] mode,
                       input logic [63:0] val, input logic [15:0] rep);
        UPDATE           = 1'b1;
        REQ_RD_SEGMENT   = seg;
        TRANSITION_MODE  = mode;
        TRANSITION_VALUE = val;
        REP              = rep;
        tick();
        UPDATE = 1'b0;
    endtask

    task automatic step(input logic [14:0] idx);
        IDX_STEP = 1'b1;
        IDX      = idx;
        tick();
        IDX_STEP = 1'b0;
    endtask

    // One full pass over a CYCLE=3 segment, ending on the wrap step
    task automatic do_loop();
        step(15'd1);
        step(15'd2);
        step(15'd3);
        step(15'd0);
    endtask

    initial begin
        RST = 1'b1; UPDATE = 1'b0; REQ_RD_SEGMENT = 1'b0; TRANSITION_MODE = 8'h00;
        TRANSITION_VALUE = '0; REP = 16'hFFFF; SYS_TIME = '0; GPIO_IN = '0;
        IDX_STEP = 1'b0; IDX = '0; CYCLE = 15'd3;
        tick(); tick();
        expect_out("reset", 0, 0, 0, 16'd0, 0);
        RST = 1'b0;

        // 1: immediate switch, BUSY for exactly one cycle
        arm(1'b1, 8'hFF, 64'd0, 16'hFFFF);
        expect_out("imm_arm", 0, 0, 1, 16'd0, 0);
        tick();
        expect_out("imm_switch", 1, 0, 0, 16'd0, 0);
        tick();
        expect_out("imm_hold", 1, 0, 0, 16'd0, 0);

        // 2: SYNC_IDX, the switching wrap is not counted
        do_loop();
        expect_out("run_wrap_count", 1, 0, 0, 16'd1, 0);
        arm(1'b0, 8'h00, 64'd0, 16'hFFFF);
        expect_out("sync_arm", 1, 0, 1, 16'd1, 0);
        step(15'd1); step(15'd2); step(15'd3);
        expect_out("sync_wait", 1, 0, 1, 16'd1, 0);
        step(15'd0);
        expect_out("sync_switch", 0, 0, 0, 16'd0, 0);

        // 3: SYS_TIME ramp to 1000, then a value already in the past
        SYS_TIME = 64'd990;
        arm(1'b1, 8'h01, 64'd1000, 16'hFFFF);
        for (int t = 991; t <= 999; t++) begin
            SYS_TIME = 64'(t);
            tick();
        end
        expect_out("time_before", 0, 0, 1, 16'd0, 0);
        SYS_TIME = 64'd1000;
        tick();
        expect_out("time_switch", 1, 0, 0, 16'd0, 0);
        SYS_TIME = 64'd1001;
        arm(1'b0, 8'h01, 64'd5, 16'hFFFF);
        expect_out("time_past_arm", 1, 0, 1, 16'd0, 0);
        tick();
        expect_out("time_past_switch", 0, 0, 0, 16'd0, 0);

        // 4: GPIO, held-high and wrong-pin pulses ignored
        GPIO_IN = 4'b0100;
        tick();
        arm(1'b1, 8'h02, 64'd2, 16'hFFFF);
        expect_out("gpio_arm", 0, 0, 1, 16'd0, 0);
        tick();
        expect_out("gpio_held", 0, 0, 1, 16'd0, 0);
        GPIO_IN = 4'b0110; tick();
        expect_out("gpio_other_pin", 0, 0, 1, 16'd0, 0);
        GPIO_IN = 4'b0100; tick();
        GPIO_IN = 4'b0000; tick();
        expect_out("gpio_fall", 0, 0, 1, 16'd0, 0);
        GPIO_IN = 4'b0100; tick();
        expect_out("gpio_switch", 1, 0, 0, 16'd0, 0);
        // an edge in the arming cycle itself is not seen
        GPIO_IN = 4'b0000; tick();
        GPIO_IN = 4'b0100;
        arm(1'b0, 8'h02, 64'd2, 16'hFFFF);
        tick();
        expect_out("gpio_arm_edge", 1, 0, 1, 16'd0, 0);
        GPIO_IN = 4'b0000; tick();
        GPIO_IN = 4'b0100; tick();
        expect_out("gpio_switch2", 0, 0, 0, 16'd0, 0);
        GPIO_IN = 4'b0000;

        // 5: REP=2 stops on the third wrap, then REP=0 plays once
        arm(1'b1, 8'hFF, 64'd0, 16'd2);
        tick();
        expect_out("rep2_switch", 1, 0, 0, 16'd0, 0);
        do_loop(); expect_out("rep2_loop1", 1, 0, 0, 16'd1, 0);
        do_loop(); expect_out("rep2_loop2", 1, 0, 0, 16'd2, 0);
        do_loop(); expect_out("rep2_stop", 1, 1, 0, 16'd3, 0);
        do_loop(); expect_out("rep2_held", 1, 1, 0, 16'd3, 0);
        arm(1'b0, 8'hFF, 64'd0, 16'd0);
        expect_out("rep0_arm", 1, 1, 1, 16'd3, 0);
        tick();
        expect_out("rep0_switch", 0, 0, 0, 16'd0, 0);
        do_loop(); expect_out("rep0_stop", 0, 1, 0, 16'd1, 0);

        // 6: bad mode keeps pending request; replacement; coincident UPDATE; reset
        arm(1'b1, 8'h00, 64'd0, 16'hFFFF);
        expect_out("pend_arm", 0, 1, 1, 16'd1, 0);
        arm(1'b0, 8'h07, 64'd0, 16'd0);
        expect_out("bad_mode", 0, 1, 1, 16'd1, 1);
        do_loop();
        expect_out("pend_switch", 1, 0, 0, 16'd0, 1);
        arm(1'b0, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF);
        arm(1'b0, 8'h00, 64'd0, 16'hFFFF);
        expect_out("replace_wait", 1, 0, 1, 16'd0, 1);
        do_loop();
        expect_out("replace_switch", 0, 0, 0, 16'd0, 1);
        arm(1'b1, 8'h00, 64'd0, 16'hFFFF);
        step(15'd1); step(15'd2); step(15'd3);
        IDX_STEP = 1'b1; IDX = 15'd0;
        arm(1'b1, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF);
        IDX_STEP = 1'b0;
        expect_out("update_beats_cond", 0, 0, 1, 16'd1, 1);
        do_loop();
        expect_out("still_waiting", 0, 0, 1, 16'd2, 1);
        RST = 1'b1; tick(); RST = 1'b0;
        expect_out("reset_in_wait", 0, 0, 0, 16'd0, 0);
        SYS_TIME = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        expect_out("request_dropped", 0, 0, 0, 16'd0, 0);

        tick();
        stim_done = 1'b1;
        wait (final_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
